// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants, receive FSM state type and the
//                oversample divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Clocks per oversample tick; never below 1 so the divider stays legal.
    function automatic int calc_div(input int clk_freq, input int baud);
        int div;
        div = clk_freq / (baud * OVERSAMPLE);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running 0..DIV-1 divider producing a one-cycle tick at
//                DIV-1. A synchronous clear realigns the phase to an event.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Divider counter: wraps at DIV-1, restarts from zero on clear.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 16x oversampling 8N1 UART receiver feeding a first-word
//                fall-through FIFO. Flags framing errors and overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [7:0]                   dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    import uart_pkg::*;

    localparam int                  c_div      = calc_div(CLK_FREQ, BAUD);
    localparam int                  c_aw       = $clog2(FIFO_DEPTH);
    localparam int                  c_tick_w   = $clog2(OVERSAMPLE);
    localparam int                  c_bit_w    = $clog2(UART_DATA_W);
    localparam logic [c_tick_w-1:0] c_half     = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tick_w-1:0] c_full     = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(UART_DATA_W - 1);
    localparam logic [c_aw:0]       c_depth    = (c_aw + 1)'(FIFO_DEPTH);

    // ---------------- input synchroniser and start-edge detect -------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic w_fall;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // ---------------- oversample tick ---------------------------------------
    logic w_tick, w_baud_clr;

    uart_baud_gen #(.DIV(c_div)) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_baud_clr),
        .o_tick (w_tick)
    );

    // ---------------- receive FSM -------------------------------------------
    uart_rx_state_t         r_state, w_state_nxt;
    logic [c_tick_w-1:0]    r_tick_cnt, w_tick_cnt_nxt;
    logic [c_bit_w-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
    logic                   w_push, w_ferr;
    logic                   r_frame_err;

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
        end
    end

    // Next state: count ticks to bit centres, sample, shift LSB first.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_push         = 1'b0;
        w_ferr         = 1'b0;
        w_baud_clr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_baud_clr     = 1'b1;
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_half) begin
                        w_tick_cnt_nxt = '0;
                        // A line already high again at mid-start is a glitch.
                        w_state_nxt    = r_rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_full) begin
                        w_tick_cnt_nxt = '0;
                        w_shift_nxt    = {r_rx_sync, r_shift[UART_DATA_W-1:1]};
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_bit_last) begin
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_full) begin
                        w_tick_cnt_nxt = '0;
                        if (r_rx_sync) begin
                            w_push      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ferr      = 1'b1;
                            w_state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until a break releases so it cannot retrigger.
                if (r_rx_sync) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- output FIFO -------------------------------------------
    logic [UART_DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]        r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]          r_count;
    logic                   r_overrun;
    logic                   w_full, w_pop, w_wr;

    assign w_full = (r_count == c_depth);
    assign w_pop  = (r_count != '0) & dout_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr   = w_push & (~w_full | w_pop);

    // Storage write; contents need no reset because the count gates the head.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Pointers, occupancy and the overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_overrun <= w_push & w_full & ~w_pop;
        end
    end

    assign dout       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign dout_valid = (r_count != '0);
    assign count      = r_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
